// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Holds the program counter, drives it
//                as the instruction-memory address, and captures the returned
//                instruction word with its PC+4 into the IF/ID register.
//                Handles hazard stalls, branch/jump redirects, IF/ID flushes
//                and keeps a count of valid instructions handed to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   input  logic        flush,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_in,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] c_PC_STEP   = 32'd4;
   localparam logic [31:0] c_ZERO_WORD = 32'd0;

   // Program counter and IF/ID pipeline register state
   logic [31:0] r_pc;
   logic [31:0] r_if_id_inst;
   logic [31:0] r_if_id_pc_plus4;
   logic        r_if_id_valid;
   logic [31:0] r_fetch_count;

   // Sequential-path PC; 32-bit addition wraps naturally at 2^32
   logic [31:0] w_pc_plus4;
   // Redirect target with the byte offset forced to a word boundary
   logic [31:0] w_redirect_pc;
   // IF/ID squash request: a redirect always kills the wrong-path fetch
   logic        w_squash;
   // IF/ID is written with a real instruction this cycle
   logic        w_load_valid;

   // Combinational helpers for the next-state logic
   always_comb begin
      w_pc_plus4    = r_pc + c_PC_STEP;
      w_redirect_pc = {redirect_addr[31:2], 2'b00};
      w_squash      = flush | redirect;
      w_load_valid  = ~w_squash & ~stall;
   end

   // PC register: redirect wins over stall, otherwise advance by one word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (redirect) begin
         r_pc <= w_redirect_pc;
      end else if (!stall) begin
         r_pc <= w_pc_plus4;
      end
   end

   // IF/ID register: squash beats stall, stall holds, otherwise capture fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_if_id_inst     <= NOP_INST;
         r_if_id_pc_plus4 <= c_ZERO_WORD;
         r_if_id_valid    <= 1'b0;
      end else if (w_squash) begin
         r_if_id_inst     <= NOP_INST;
         r_if_id_pc_plus4 <= c_ZERO_WORD;
         r_if_id_valid    <= 1'b0;
      end else if (!stall) begin
         r_if_id_inst     <= inst_in;
         r_if_id_pc_plus4 <= w_pc_plus4;
         r_if_id_valid    <= 1'b1;
      end
   end

   // Debug counter of valid instructions loaded into IF/ID; wraps at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_count <= c_ZERO_WORD;
      end else if (w_load_valid) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   // Outputs come straight from registers; inst_addr has no input-to-output path
   always_comb begin
      inst_addr      = r_pc;
      if_id_inst     = r_if_id_inst;
      if_id_pc_plus4 = r_if_id_pc_plus4;
      if_id_valid    = r_if_id_valid;
      fetch_count    = r_fetch_count;
   end

endmodule
`default_nettype wire
